bus_select_pipe: RTL and testbench

//  Parametrised N-source bus selector with registered, flow-controlled output for the processor datapath.

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_src_mux.sv | 19 +
 rtl/bus_select_pipe.sv | 77 +++++++
 tb/tb_bus_select_pipe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared select codes and the occupancy state type for the bus selector
package bus_pkg;
  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_R3 = 4'd3;
  localparam logic [3:0] SEL_R4 = 4'd4;
  localparam logic [3:0] SEL_R5 = 4'd5;
  localparam logic [3:0] SEL_AR = 4'd6;
  localparam logic [3:0] SEL_AC = 4'd7;
  localparam logic [3:0] SEL_IR = 4'd8;
  localparam logic [3:0] SEL_PRAM = 4'd9;
  localparam logic [3:0] SEL_DRAM = 4'd10;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/bus_src_mux.sv
// bus_src_mux: combinational decode of a source code into {data, illegal}; ports sel/src_data in, data/illegal out
module bus_src_mux #(
  parameter int DATA_W = 16,
  parameter int NUM_SRC = 10,
  parameter int SEL_W = 4,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      illegal
);
  always_comb begin
    data = DEFAULT_VAL;
    for (int k = 0; k < NUM_SRC; k++)
      if (sel == SEL_W'(k + 1)) data = src_data[k*DATA_W +: DATA_W];
  end
  assign illegal = sel > SEL_W'(NUM_SRC);
endmodule

// File: rtl/bus_select_pipe.sv
// bus_select_pipe: N-source bus selector with registered valid/ready output, 2-entry skid, tag, error pulse and transfer count; ports clk/rst, src_data/sel/req_valid/req_ready in-side, bus_data/bus_src/bus_valid/bus_ready out-side, sel_err, xfer_cnt
module bus_select_pipe
  import bus_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_SRC = 10,
  parameter int SEL_W = 4,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [DATA_W-1:0]         bus_data,
  output logic [SEL_W-1:0]          bus_src,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      sel_err,
  output logic [15:0]               xfer_cnt
);
  occ_t state, state_n;
  logic [DATA_W-1:0] mux_data, skid_data;
  logic [SEL_W-1:0] skid_src;
  logic illegal, accept, pop, load_out, load_skid, skid_to_out;
  bus_src_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEFAULT_VAL(DEFAULT_VAL)) u_mux (
    .src_data(src_data),
    .sel(sel),
    .data(mux_data),
    .illegal(illegal)
  );
  assign bus_valid = state != EMPTY;
  assign accept = req_valid & req_ready;
  assign pop = bus_valid & bus_ready;
  assign load_out = accept & (state == EMPTY | (state == ONE & pop));
  assign load_skid = accept & state == ONE & !pop;
  assign skid_to_out = state == TWO & pop;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY: state_n = accept ? ONE : EMPTY;
      ONE: state_n = (accept & !pop) ? TWO : (!accept & pop) ? EMPTY : ONE;
      TWO: state_n = pop ? ONE : TWO;
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      req_ready <= 1'b1;
      bus_data <= '0;
      bus_src <= '0;
      skid_data <= '0;
      skid_src <= '0;
      sel_err <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state <= state_n;
      // ready is registered from the next occupancy so req_valid never reaches req_ready combinationally
      req_ready <= state_n != TWO;
      sel_err <= accept & illegal;
      xfer_cnt <= xfer_cnt + 16'(pop);
      if (load_out) begin
        bus_data <= mux_data;
        bus_src <= sel;
      end else if (skid_to_out) begin
        bus_data <= skid_data;
        bus_src <= skid_src;
      end
      if (load_skid) begin
        skid_data <= mux_data;
        skid_src <= sel;
      end
    end
  end
endmodule

// File: tb/tb_bus_select_pipe.sv
// tb_bus_select_pipe: directed plus randomized checks of bus_select_pipe against a queue-based reference model
module tb_bus_select_pipe;
  logic clk = 0, rst = 1, req_valid = 0, bus_ready = 0;
  logic [159:0] src_data = '0;
  logic [3:0] sel = '0, bus_src;
  logic req_ready, bus_valid, sel_err;
  logic [15:0] bus_data, xfer_cnt;
  int tests = 0, failed = 0, err_pulses = 0;
  logic [15:0] qd[$];
  logic [3:0] qs[$];
  logic exp_err = 0;
  logic [15:0] exp_cnt = 0;
  bus_select_pipe dut (
    .clk(clk), .rst(rst), .src_data(src_data), .sel(sel), .req_valid(req_valid),
    .req_ready(req_ready), .bus_data(bus_data), .bus_src(bus_src), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] decode(input logic [3:0] s, input logic [159:0] src);
    return (s >= 1 && s <= 10) ? src[(int'(s) - 1)*16 +: 16] : 16'h0000;
  endfunction
  task automatic step();
    bit acc, pp;
    logic [15:0] d;
    logic [3:0] s;
    acc = !rst && req_valid && qd.size() < 2;
    pp = !rst && qd.size() > 0 && bus_ready;
    d = decode(sel, src_data);
    s = sel;
    @(posedge clk);
    #1;
    if (rst) begin
      qd.delete();
      qs.delete();
      exp_err = 0;
      exp_cnt = 0;
    end else begin
      if (pp) begin
        void'(qd.pop_front());
        void'(qs.pop_front());
        exp_cnt++;
      end
      if (acc) begin
        qd.push_back(d);
        qs.push_back(s);
      end
      exp_err = acc && s > 10;
    end
    if (sel_err) err_pulses++;
    chk("bus_valid", 32'(bus_valid), 32'(qd.size() > 0));
    chk("req_ready", 32'(req_ready), 32'(qd.size() < 2));
    chk("sel_err", 32'(sel_err), 32'(exp_err));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    if (qd.size() > 0) begin
      chk("bus_data", 32'(bus_data), 32'(qd[0]));
      chk("bus_src", 32'(bus_src), 32'(qs[0]));
    end
  endtask
  task automatic set_src(input int k, input logic [15:0] v);
    src_data[(k - 1)*16 +: 16] = v;
  endtask
  initial begin
    rst = 1;
    step();
    step();
    chk("reset_bus_data", 32'(bus_data), 32'h0);
    chk("reset_bus_src", 32'(bus_src), 32'h0);
    rst = 0;
    // 1: single AC transfer
    set_src(7, 16'h1234);
    sel = 4'd7;
    req_valid = 1;
    bus_ready = 1;
    step();
    chk("t1_data", 32'(bus_data), 32'h1234);
    chk("t1_src", 32'(bus_src), 32'h7);
    req_valid = 0;
    step();
    chk("t1_cnt", 32'(xfer_cnt), 32'h1);
    // 2: backpressure fills skid, then drains in order
    bus_ready = 0;
    set_src(1, 16'h0001);
    set_src(2, 16'h0002);
    req_valid = 1;
    sel = 4'd1;
    step();
    sel = 4'd2;
    step();
    chk("t2_ready_full", 32'(req_ready), 32'h0);
    // 4: source changes while stalled do not affect buffered entries
    set_src(1, 16'hdead);
    set_src(2, 16'hbeef);
    req_valid = 0;
    step();
    bus_ready = 1;
    chk("t2_first", 32'(bus_data), 32'h0001);
    step();
    chk("t2_second", 32'(bus_data), 32'h0002);
    step();
    // 3: code 0 and illegal code 12
    err_pulses = 0;
    set_src(1, 16'h5555);
    req_valid = 1;
    sel = 4'd0;
    step();
    chk("t3_none", 32'(bus_data), 32'h0);
    sel = 4'd12;
    step();
    chk("t3_illegal", 32'(bus_data), 32'h0);
    chk("t3_tag", 32'(bus_src), 32'hc);
    req_valid = 0;
    step();
    step();
    chk("t3_err_once", 32'(err_pulses), 32'h1);
    // 5: reset while two entries are held
    bus_ready = 0;
    req_valid = 1;
    sel = 4'd3;
    step();
    step();
    chk("t5_two", 32'(req_ready), 32'h0);
    req_valid = 0;
    rst = 1;
    step();
    rst = 0;
    bus_ready = 1;
    chk("t5_valid", 32'(bus_valid), 32'h0);
    chk("t5_cnt", 32'(xfer_cnt), 32'h0);
    step();
    step();
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 1);
      bus_ready = ($urandom_range(0, 3) != 0);
      sel = 4'($urandom_range(0, 15));
      for (int k = 1; k <= 10; k++) set_src(k, 16'($urandom));
      step();
    end
    // 6: sustained accept+pop every cycle until the counter wraps
    rst = 1;
    step();
    rst = 0;
    req_valid = 1;
    bus_ready = 1;
    for (int i = 0; i < 65537; i++) begin
      sel = 4'($urandom_range(1, 10));
      set_src(int'(sel), 16'($urandom));
      step();
    end
    chk("t6_wrap", 32'(xfer_cnt), 32'h0);
    chk("t6_ready", 32'(req_ready), 32'h1);
    req_valid = 0;
    step();
    chk("t6_after_wrap", 32'(xfer_cnt), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
